// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
// ----------------
// A chain of DEPTH elastic register stages carrying a WIDTH-bit payload
// between two pipeline stages of the core. The chain collapses bubbles, can
// kill any held entry, and drops kill_in entries at the input. Empty, killed
// and reset stages hold NOP_VALUE.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is a combinational function of out_ready, flush_mask
// and the stage state; there is no skid buffer. out_valid, once high, stays
// high with stable out_data until out_ready or a kill of the last stage.
//
// Optional feature: define PIPE_STAT_EN to build the saturating stall_cnt
// and kill_cnt counters. Without it both outputs are tied to zero.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   in_valid    upstream offers in_data
//   in_ready    chain accepts in_data this cycle
//   in_data     upstream payload
//   kill_in     drop the entry offered this cycle (handshake still completes)
//   flush_mask  bit i kills the entry held in stage i (stage 0 nearest input)
//   out_valid   last stage holds a live entry
//   out_ready   downstream accepts out_data
//   out_data    payload of the last stage (NOP_VALUE when not valid)
//   occupancy   number of valid stage registers (ignores flush_mask)
//   stall_cnt   cycles with in_valid=1 and in_ready=0 (PIPE_STAT_EN)
//   kill_cnt    number of entries killed (PIPE_STAT_EN)
module pipe_stage_chain #(
  parameter int unsigned       WIDTH     = 64,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
  parameter int unsigned       CNT_W     = 16,
  localparam int unsigned      OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             kill_in,
  input  logic [DEPTH-1:0] flush_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] kill_cnt
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  logic [DEPTH-1:0] ev;   // stage holds an entry that is not being killed
  logic [DEPTH-1:0] rdy;  // stage can take from its source this edge
  logic             evin; // input offers an entry that survives kill_in
  logic             ready_acc;
  logic [OCC_W-1:0] occ;

  // Ready ripples from the output back toward the input: a stage is free if
  // it holds nothing live, or if everything ahead of it is moving.
  always_comb begin
    ev        = valid_q & ~flush_mask;
    evin      = in_valid & ~kill_in;
    ready_acc = out_ready;
    rdy       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready_acc = ~ev[i] | ready_acc;
      rdy[i]    = ready_acc;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (rdy[0]) begin
      valid_d[0] = evin;
      data_d[0]  = evin ? in_data : NOP_VALUE;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        valid_d[i] = ev[i-1];
        data_d[i]  = ev[i-1] ? data_q[i-1] : NOP_VALUE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= NOP_VALUE;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(valid_q[i]);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = ev[DEPTH-1];
  // A killed last stage still holds its old payload for this cycle; mask it
  // so out_data is NOP_VALUE whenever out_valid is low.
  assign out_data  = ev[DEPTH-1] ? data_q[DEPTH-1] : NOP_VALUE;
  assign occupancy = occ;

`ifdef PIPE_STAT_EN
  localparam int unsigned KW    = OCC_W + 1;
  localparam int unsigned SUM_W = CNT_W + KW;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
  logic [KW-1:0]    kills;
  logic [SUM_W-1:0] kill_sum;

  // Kills this cycle: held entries hit by flush_mask plus an accepted
  // entry dropped by kill_in. The sum is widened so saturation is exact.
  always_comb begin
    kills = KW'(in_valid & rdy[0] & kill_in);
    for (int i = 0; i < DEPTH; i++) begin
      kills = kills + KW'(valid_q[i] & flush_mask[i]);
    end
    kill_sum = SUM_W'(kill_cnt_q) + SUM_W'(kills);
    if (kill_sum > SUM_W'({CNT_W{1'b1}})) begin
      kill_cnt_d = '1;
    end else begin
      kill_cnt_d = kill_sum[CNT_W-1:0];
    end
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !rdy[0] && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign kill_cnt  = kill_cnt_q;
`else
  assign stall_cnt = '0;
  assign kill_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain (DEPTH=4, WIDTH=16, NOP_VALUE=16'hDEAD,
// CNT_W=4 so counter saturation is reachable). A slot-level model of the
// chain is compared against the DUT on every falling edge; directed phases
// pin the model with hand-computed literal expectations.
module tb_pipe_stage_chain;

  localparam int          D    = 4;
  localparam int          W    = 16;
  localparam int          CW   = 4;
  localparam int          CMAX = 15;
  localparam logic [W-1:0] NOP = 16'hDEAD;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT ----------------
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          kill_in = 1'b0;
  logic [D-1:0]  flush_mask = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [2:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] kill_cnt;

  pipe_stage_chain #(
    .WIDTH(W), .DEPTH(D), .NOP_VALUE(NOP), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .kill_in(kill_in), .flush_mask(flush_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Slots 0..D-1, slot D-1 at the output. An entry leaves the chain when it
  // sits in the last slot and downstream is ready; a flushed entry vanishes.
  // A live entry stays put only if it and every entry ahead of it are live
  // and the output is blocked; otherwise it slides one slot forward.
  logic         mv [D];
  logic [W-1:0] md [D];
  int           m_stall, m_kill;

  logic         nv [D];
  logic [W-1:0] nd [D];
  logic         live_t [D];
  logic         stay_t [D];
  int           live_n, kills_n;
  logic         m_rdy, acc_t;

  always_comb begin
    live_n  = 0;
    kills_n = 0;
    for (int i = 0; i < D; i++) begin
      live_t[i] = mv[i] && !flush_mask[i];
      if (live_t[i]) live_n = live_n + 1;
      if (mv[i] && flush_mask[i]) kills_n = kills_n + 1;
    end
    m_rdy = out_ready || (live_n < D);
    acc_t = in_valid && m_rdy;
    if (acc_t && kill_in) kills_n = kills_n + 1;
    for (int i = 0; i < D; i++) begin
      stay_t[i] = !out_ready;
      for (int j = i; j < D; j++) begin
        if (!live_t[j]) stay_t[i] = 1'b0;
      end
    end
    for (int i = 0; i < D; i++) begin
      nv[i] = mv[i];
      nd[i] = md[i];
      if (!stay_t[i]) begin
        if (i == 0) begin
          nv[i] = acc_t && !kill_in;
          nd[i] = (acc_t && !kill_in) ? in_data : NOP;
        end else begin
          nv[i] = live_t[i-1];
          nd[i] = live_t[i-1] ? md[i-1] : NOP;
        end
      end
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < D; i++) begin
        mv[i] <= 1'b0;
        md[i] <= NOP;
      end
      m_stall <= 0;
      m_kill  <= 0;
    end else begin
      for (int i = 0; i < D; i++) begin
        mv[i] <= nv[i];
        md[i] <= nd[i];
      end
      if (in_valid && !m_rdy && m_stall < CMAX) m_stall <= m_stall + 1;
      m_kill <= (m_kill + kills_n > CMAX) ? CMAX : m_kill + kills_n;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (run_cmp) begin
      int occ_m;
      occ_m = 0;
      for (int i = 0; i < D; i++) if (mv[i]) occ_m = occ_m + 1;
      chk("cmp_out_valid", out_valid, mv[D-1] && !flush_mask[D-1]);
      if (mv[D-1] && !flush_mask[D-1]) chk("cmp_out_data", out_data, md[D-1]);
      else if (!mv[D-1])               chk("cmp_out_data", out_data, NOP);
      chk("cmp_in_ready", in_ready, m_rdy);
      chk("cmp_occupancy", occupancy, occ_m);
`ifdef PIPE_STAT_EN
      chk("cmp_stall_cnt", stall_cnt, m_stall);
      chk("cmp_kill_cnt", kill_cnt, m_kill);
`else
      chk("cmp_stall_cnt", stall_cnt, 0);
      chk("cmp_kill_cnt", kill_cnt, 0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    kill_in    = 1'b0;
    flush_mask = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t1_occ [9];
    logic          ev_v;
    logic [W-1:0]  ev_d;

    // Reset state
    @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, NOP);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_kill_cnt", kill_cnt, 0);
    #2 reset = 1'b1;
    run_cmp = 1'b1;

    // Latency / throughput: push A,B,C with out_ready=1
    t1_occ = '{0, 1, 2, 3, 3, 2, 1, 0, 0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h000A;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 1) in_data = 16'h000B;
      if (c == 2) in_data = 16'h000C;
      if (c == 3) in_valid = 1'b0;
      ev_v = (c >= 4 && c <= 6);
      ev_d = (c == 4) ? 16'h000A : (c == 5) ? 16'h000B : (c == 6) ? 16'h000C : NOP;
      chk("lat_out_valid", out_valid, ev_v);
      chk("lat_out_data", out_data, ev_d);
      chk("lat_occupancy", occupancy, t1_occ[c]);
    end

    // Fill with out_ready=0: four accepted, fifth stalls
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    for (int k = 0; k < 4; k++) begin
      cyc();
      in_data = 16'h0012 + 16'(k);
    end
    chk("full_occupancy", occupancy, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_data", out_data, 16'h0011);
    repeat (18) cyc();
    chk("stall_occupancy", occupancy, 4);
    chk("stall_out_data", out_data, 16'h0011);
`ifdef PIPE_STAT_EN
    chk("stall_cnt_sat", stall_cnt, 15);
`endif
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 1);
    cyc();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("one_out_data", out_data, 16'h0012);
    chk("one_occupancy", occupancy, 4);

    // Flush stages 0 and 1 while the output is blocked
    flush_mask = 4'b0011;
    #1;
    chk("flush_out_valid", out_valid, 1);
    chk("flush_in_ready", in_ready, 1);
    cyc();
    flush_mask = '0;
    chk("flush_occupancy", occupancy, 2);
    chk("flush_out_data", out_data, 16'h0012);
`ifdef PIPE_STAT_EN
    chk("flush_kill_cnt", kill_cnt, 2);
`endif
    out_ready = 1'b1;
    cyc();
    chk("drain_out_data", out_data, 16'h0013);
    cyc();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_occupancy", occupancy, 0);

    // kill_in on an empty chain: handshake completes, nothing emerges
    in_valid = 1'b1;
    kill_in  = 1'b1;
    in_data  = 16'h0077;
    #1;
    chk("kill_in_ready", in_ready, 1);
    cyc();
    idle_inputs();
    for (int c = 0; c < D + 2; c++) begin
      chk("kill_out_valid", out_valid, 0);
      chk("kill_occupancy", occupancy, 0);
      cyc();
    end
`ifdef PIPE_STAT_EN
    chk("kill_in_kill_cnt", kill_cnt, 3);
`endif

    // Bubble collapse: entries in stages 0 and 3, output blocked
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0031;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    in_valid = 1'b1;
    in_data  = 16'h0032;
    cyc();
    chk("bub_occupancy0", occupancy, 2);
    chk("bub_out_data0", out_data, 16'h0031);
    in_data = 16'h0033;
    #1;
    chk("bub_in_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk("bub_occupancy1", occupancy, 3);
    chk("bub_out_data1", out_data, 16'h0031);

    // Kill the last stage with out_ready=0: it empties and refills
    flush_mask = 4'b1000;
    #1;
    chk("klast_out_valid", out_valid, 0);
    chk("klast_out_data", out_data, NOP);
    chk("klast_in_ready", in_ready, 1);
    cyc();
    flush_mask = '0;
    chk("klast_occupancy", occupancy, 2);
`ifdef PIPE_STAT_EN
    chk("klast_kill_cnt", kill_cnt, 4);
`endif
    out_ready = 1'b1;
    repeat (6) cyc();
    chk("klast_drained", occupancy, 0);

    // Mixed traffic checked by the model
    for (int c = 0; c < 300; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 16'($urandom_range(0, 16'hFFFF));
      kill_in    = ($urandom_range(0, 7) == 0);
      flush_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      out_ready  = ($urandom_range(0, 2) != 0);
      cyc();
    end
    idle_inputs();
    out_ready = 1'b1;
    repeat (6) cyc();

    // Reset mid-stream with three entries in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0051;
    cyc();
    in_data = 16'h0052;
    cyc();
    in_data = 16'h0053;
    cyc();
    in_data = 16'h0099;
    chk("prerst_occupancy", occupancy, 3);
    #1 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, NOP);
    chk("arst_occupancy", occupancy, 0);
    @(posedge clock);
    @(negedge clock);
    #2;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("postrst_occupancy", occupancy, 0);
    chk("postrst_out_valid", out_valid, 0);

    // One entry after reset goes through with full latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0061;
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("post_out_valid", out_valid, 1);
    chk("post_out_data", out_data, 16'h0061);
    cyc();
    chk("post_empty", out_valid, 0);

    @(negedge clock);
    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
